// File: rtl/mux_key_with_default.sv
// Key-lookup multiplexer with default value.
// Compares key against NR_KEY packed (key, data) pairs; the lowest matching
// index wins. Provides the combinational result plus a registered copy.
module mux_key_with_default #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1,
    localparam int unsigned IDX_W   = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    input  logic                                 en,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit,
    output logic [IDX_W-1:0]                     hit_idx,
    output logic                                 dup,
    output logic [DATA_LEN-1:0]                  out_q,
    output logic                                 hit_q,
    output logic [IDX_W-1:0]                     idx_q
);

    localparam int unsigned P = KEY_LEN + DATA_LEN;

    logic [NR_KEY-1:0] match;

    // Per-entry exact key comparison; key sits in the upper bits of each slice.
    always_comb begin
        match = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            match[n] = (lut[n*P + DATA_LEN +: KEY_LEN] == key);
        end
    end

    // Priority select: walk from the top so the lowest matching index is applied last.
    always_comb begin
        out     = default_out;
        hit     = 1'b0;
        hit_idx = '0;
        for (int n = NR_KEY - 1; n >= 0; n--) begin
            if (match[n]) begin
                out     = lut[n*P +: DATA_LEN];
                hit     = 1'b1;
                hit_idx = IDX_W'(n);
            end
        end
    end

    // Two or more matches: clearing the lowest set bit leaves something behind.
    always_comb begin
        dup = |(match & (match - NR_KEY'(1)));
    end

    // Registered copy of the lookup result, captured when en is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            hit_q <= 1'b0;
            idx_q <= '0;
        end else if (en) begin
            out_q <= out;
            hit_q <= hit;
            idx_q <= hit_idx;
        end
    end

endmodule

// File: tb/tb_mux_key_with_default.sv
// Scoreboard bench for mux_key_with_default: a single-entry instance and a
// four-entry instance. Stimulus queues expected values; a monitor compares
// them against the DUT whenever a sample is requested.
module tb_mux_key_with_default;

    // Field selectors for the monitor.
    localparam int F_OUT1  = 0;
    localparam int F_HIT1  = 1;
    localparam int F_IDX1  = 2;
    localparam int F_DUP1  = 3;
    localparam int F_OUT4  = 4;
    localparam int F_HIT4  = 5;
    localparam int F_IDX4  = 6;
    localparam int F_DUP4  = 7;
    localparam int F_OUTQ  = 8;
    localparam int F_HITQ  = 9;
    localparam int F_IDXQ  = 10;

    typedef struct {
        string       name;
        int          field;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic rst;

    // Single-entry instance.
    logic       key1, def1, en1;
    logic [1:0] lut1;
    logic       out1, hit1, idx1, dup1, out1_q, hit1_q, idx1_q;

    // Four-entry instance.
    logic [2:0]  key4;
    logic [7:0]  def4;
    logic [43:0] lut4;
    logic        en4;
    logic [7:0]  out4, out4_q;
    logic        hit4, dup4, hit4_q;
    logic [1:0]  idx4, idx4_q;

    mux_key_with_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .key(key1), .default_out(def1), .lut(lut1), .en(en1),
        .out(out1), .hit(hit1), .hit_idx(idx1), .dup(dup1),
        .out_q(out1_q), .hit_q(hit1_q), .idx_q(idx1_q)
    );

    mux_key_with_default #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8)) u_dut4 (
        .clk(clk), .rst(rst), .key(key4), .default_out(def4), .lut(lut4), .en(en4),
        .out(out4), .hit(hit4), .hit_idx(idx4), .dup(dup4),
        .out_q(out4_q), .hit_q(hit4_q), .idx_q(idx4_q)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] field_val(input int f);
        case (f)
            F_OUT1:  return 32'(out1);
            F_HIT1:  return 32'(hit1);
            F_IDX1:  return 32'(idx1);
            F_DUP1:  return 32'(dup1);
            F_OUT4:  return 32'(out4);
            F_HIT4:  return 32'(hit4);
            F_IDX4:  return 32'(idx4);
            F_DUP4:  return 32'(dup4);
            F_OUTQ:  return 32'(out4_q);
            F_HITQ:  return 32'(hit4_q);
            F_IDXQ:  return 32'(idx4_q);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drains the scoreboard against the live outputs on each sample.
    initial begin
        exp_t        it;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = field_val(it.field);
                checks++;
                if (act !== it.value) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h", it.name, act, it.value);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int field, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.field = field;
        e.value = value;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then hand the queue to the monitor.
    task automatic sample();
        #1;
        ->sample_ev;
        #1;
    endtask

    // Advance past one rising edge, landing just after the following falling edge.
    task automatic cross_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_reg(input string tag, input logic [7:0] o, input logic h,
                              input logic [1:0] i);
        expect_val({tag, " out_q"}, F_OUTQ, 32'(o));
        expect_val({tag, " hit_q"}, F_HITQ, 32'(h));
        expect_val({tag, " idx_q"}, F_IDXQ, 32'(i));
    endtask

    logic [7:0] sweep_out [8] = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'hEE, 8'h55, 8'hEE, 8'h77};
    logic       sweep_hit [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] sweep_idx [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3};

    localparam logic [43:0] LUT_FOUR = {3'd7, 8'h77, 3'd5, 8'h55, 3'd2, 8'h22, 3'd0, 8'h11};

    initial begin
        rst  = 1'b1;
        key1 = 1'b0; def1 = 1'b0; en1 = 1'b0; lut1 = {1'b0, 1'b1};
        key4 = 3'd0; def4 = 8'hEE; en4 = 1'b0; lut4 = LUT_FOUR;

        // Reset state of the registered stage.
        expect_reg("reset", 8'h00, 1'b0, 2'd0);
        sample();

        // Single-entry table.
        key1 = 1'b0;
        expect_val("one key0 out", F_OUT1, 32'd1);
        expect_val("one key0 hit", F_HIT1, 32'd1);
        expect_val("one key0 dup", F_DUP1, 32'd0);
        expect_val("one key0 idx", F_IDX1, 32'd0);
        sample();
        key1 = 1'b1;
        expect_val("one key1 out", F_OUT1, 32'd0);
        expect_val("one key1 hit", F_HIT1, 32'd0);
        sample();
        def1 = 1'b1;
        expect_val("one key1 default", F_OUT1, 32'd1);
        expect_val("one key1 idx", F_IDX1, 32'd0);
        sample();

        rst = 1'b0;
        cross_edge();

        // Four-entry sweep over every key value.
        for (int k = 0; k < 8; k++) begin
            key4 = 3'(k);
            expect_val($sformatf("sweep key%0d out", k), F_OUT4, 32'(sweep_out[k]));
            expect_val($sformatf("sweep key%0d hit", k), F_HIT4, 32'(sweep_hit[k]));
            expect_val($sformatf("sweep key%0d idx", k), F_IDX4, 32'(sweep_idx[k]));
            expect_val($sformatf("sweep key%0d dup", k), F_DUP4, 32'd0);
            sample();
            if (k % 2 == 1) cross_edge();
        end

        // Duplicate keys at entries 1 and 3.
        cross_edge();
        lut4 = {3'd4, 8'hA3, 3'd6, 8'h66, 3'd4, 8'hA1, 3'd0, 8'h10};
        key4 = 3'd4;
        expect_val("dup13 out", F_OUT4, 32'hA1);
        expect_val("dup13 idx", F_IDX4, 32'd1);
        expect_val("dup13 dup", F_DUP4, 32'd1);
        expect_val("dup13 hit", F_HIT4, 32'd1);
        sample();
        // Every entry matches: entry 0 wins.
        lut4 = {3'd4, 8'hD3, 3'd4, 8'hD2, 3'd4, 8'hD1, 3'd4, 8'hD0};
        expect_val("dupall out", F_OUT4, 32'hD0);
        expect_val("dupall idx", F_IDX4, 32'd0);
        expect_val("dupall dup", F_DUP4, 32'd1);
        sample();
        // Only entries 2 and 3 match.
        lut4 = {3'd4, 8'hE3, 3'd4, 8'hE2, 3'd1, 8'hE1, 3'd3, 8'hE0};
        expect_val("dup23 out", F_OUT4, 32'hE2);
        expect_val("dup23 idx", F_IDX4, 32'd2);
        expect_val("dup23 dup", F_DUP4, 32'd1);
        sample();

        // Registered stage: capture key 5.
        cross_edge();
        lut4 = LUT_FOUR;
        key4 = 3'd5;
        en4  = 1'b1;
        cross_edge();
        expect_reg("capture5", 8'h55, 1'b1, 2'd2);
        sample();
        en4  = 1'b0;
        key4 = 3'd2;
        expect_val("hold comb out", F_OUT4, 32'h22);
        expect_val("hold comb idx", F_IDX4, 32'd1);
        expect_reg("hold same cycle", 8'h55, 1'b1, 2'd2);
        sample();
        cross_edge();
        expect_reg("hold after edge", 8'h55, 1'b1, 2'd2);
        sample();

        // Asynchronous reset between edges.
        rst = 1'b1;
        expect_reg("async reset", 8'h00, 1'b0, 2'd0);
        expect_val("reset comb out", F_OUT4, 32'h22);
        sample();
        en4 = 1'b1;
        cross_edge();
        expect_reg("reset with en", 8'h00, 1'b0, 2'd0);
        sample();
        rst  = 1'b0;
        key4 = 3'd7;
        cross_edge();
        expect_reg("after release", 8'h77, 1'b1, 2'd3);
        sample();

        // Default follow with no matching key.
        en4  = 1'b0;
        key4 = 3'd3;
        def4 = 8'h00;
        expect_val("default00 out", F_OUT4, 32'h00);
        expect_val("default00 hit", F_HIT4, 32'd0);
        expect_val("default00 idx", F_IDX4, 32'd0);
        sample();
        def4 = 8'h3C;
        expect_val("default3c out", F_OUT4, 32'h3C);
        expect_val("default3c hit", F_HIT4, 32'd0);
        expect_reg("default held", 8'h77, 1'b1, 2'd3);
        sample();
        en4 = 1'b1;
        cross_edge();
        expect_reg("default captured", 8'h3C, 1'b0, 2'd0);
        sample();
        en4 = 1'b0;

        // Scoreboard must be empty once all samples are taken.
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
